// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard.
package hazard_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [2:0] MEM_READ_NONE = 3'b000;
    localparam int DEFAULT_LOAD_LAT = 1;
    localparam int DEFAULT_MD_LAT = 8;

    // Bus is zero-extended to 64 bits by the caller; result holds one slot.
    function automatic logic [63:0] srcSlot(
        input logic [63:0] bus,
        input int k,
        input int w
    );
        return (bus >> (k * w)) & ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Mult/div occupancy down-counter with registered busy flag.
module hazard_md_timer #(
    parameter int MD_LAT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

    logic [W-1:0] count;
    logic [W-1:0] countNext;

    // A start while busy simply reloads: the later start wins.
    always_comb begin
        countNext = count;
        if (start) begin
            countNext = W'(MD_LAT - 1);
        end else if (count != '0) begin
            countNext = count - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= countNext;
            busy  <= (countNext != '0);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: multi-cycle load-use and mult/div stalls.
// Define HAZARD_PERF_CNT_EN to enable the saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_LAT   = DEFAULT_LOAD_LAT,
    parameter int MD_LAT     = DEFAULT_MD_LAT,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          id_uses_md,
    input  logic                          flush,
    input  logic                          ex_valid,
    input  logic [2:0]                    ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_wr_addr,
    input  logic                          ex_md_start,
    output logic                          pc_write,
    output logic                          stall_id,
    output logic                          bubble_ex,
    output logic                          md_busy,
    output logic [CNT_W-1:0]              stall_count
);

    localparam int PIPE_N = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

    logic                  exLoad;
    logic                  loadHz;
    logic                  mdHz;
    logic                  hz;
    logic                  mdBusyQ;
    logic [PIPE_N-1:0]     pipeValid;
    logic [REG_ADDR_W-1:0] pipeAddr [PIPE_N];
    logic [REG_ADDR_W-1:0] src [NUM_SRC];

    assign exLoad = ex_valid && (ex_mem_read != MEM_READ_NONE);

    // The shadow pipe follows EX unconditionally since EX never stalls.
    if (LOAD_LAT > 1) begin : gPipe
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pipeValid <= '0;
                for (int s = 0; s < PIPE_N; s++) begin
                    pipeAddr[s] <= '0;
                end
            end else begin
                pipeValid[0] <= exLoad && (ex_wr_addr != ZERO);
                pipeAddr[0]  <= ex_wr_addr;
                for (int s = 1; s < PIPE_N; s++) begin
                    pipeValid[s] <= pipeValid[s-1];
                    pipeAddr[s]  <= pipeAddr[s-1];
                end
            end
        end
    end else begin : gNoPipe
        assign pipeValid   = '0;
        assign pipeAddr[0] = '0;
    end

    always_comb begin
        loadHz = 1'b0;
        src = '{default: '0};
        for (int k = 0; k < NUM_SRC; k++) begin
            src[k] = REG_ADDR_W'(srcSlot(64'(id_src_addr), k, REG_ADDR_W));
            if (id_src_used[k] && (src[k] != ZERO)) begin
                if (exLoad && (ex_wr_addr == src[k])) begin
                    loadHz = 1'b1;
                end
                for (int s = 0; s < PIPE_N; s++) begin
                    if (pipeValid[s] && (pipeAddr[s] == src[k])) begin
                        loadHz = 1'b1;
                    end
                end
            end
        end
    end

    hazard_md_timer #(
        .MD_LAT(MD_LAT)
    ) uMdTimer (
        .clk  (clk),
        .rst  (rst),
        .start(ex_valid && ex_md_start),
        .busy (mdBusyQ)
    );

    assign mdHz      = id_uses_md && mdBusyQ;
    assign hz        = !rst && id_valid && !flush && (loadHz || mdHz);
    assign stall_id  = hz;
    assign bubble_ex = hz;
    assign pc_write  = !hz;
    assign md_busy   = mdBusyQ;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (hz && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

    assign stall_count = stallCnt;
`else
    assign stall_count = '0;
`endif

endmodule
